// File: rtl/game_pkg.sv
// Shared terrain/game constants, coordinate types and the carve FSM state encoding.
package game_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ROWS   = 512;
  localparam int R_MAX    = 63;

  typedef logic [9:0]                     coord_t;
  typedef logic [$clog2(R_MAX+1)-1:0]     radius_t;
  // Squares of 11-bit magnitudes; only the low 13 bits are ever non-zero.
  typedef logic [21:0]                    sq_t;

  localparam coord_t FLOOR_Y  = 10'd480;
  localparam coord_t INIT_H   = 10'd400;
  localparam coord_t LAST_COL = 10'(H_ACTIVE - 1);

  typedef enum logic [2:0] {INIT, IDLE, RD, SRCH, WR} carve_state_t;

endpackage

// File: rtl/terrain_ram.sv
// 640x10 heightmap: port A read-only (display), port B read/write (init, carve, query).
module terrain_ram
  import game_pkg::*;
(
  input  logic   clk,
  input  coord_t addr_a,
  output coord_t q_a,
  input  coord_t addr_b,
  input  logic   we_b,
  input  coord_t wd_b,
  output coord_t q_b
);

  coord_t mem [0:H_ACTIVE-1];

  // Port A: registered read for the display prefetch.
  always_ff @(posedge clk) begin
    q_a <= mem[addr_a];
  end

  // Port B: write plus registered read (old data on a same-address collision).
  always_ff @(posedge clk) begin
    if (we_b) mem[addr_b] <= wd_b;
    q_b <= mem[addr_b];
  end

endmodule

// File: rtl/terrain_column_gen.sv
// Terrain heightmap owner: column bitmap prefetch, crater carving FSM, height queries.
module terrain_column_gen
  import game_pkg::*;
(
  input  logic         Clk,
  input  logic         Reset,
  input  logic [9:0]   DrawX,
  output logic [511:0] terrain_data,
  input  logic         carve_req,
  input  logic [9:0]   carve_x,
  input  logic [9:0]   carve_y,
  input  logic [5:0]   carve_r,
  output logic         carve_busy,
  output logic         carve_done,
  input  logic [9:0]   query_x,
  output logic [9:0]   query_h
);

  carve_state_t      state_q;
  coord_t            col_q, xe_q, x_q, y_q, last_x_q, ax1_q, nc_x_q, hold_q;
  radius_t           r_q, dy_q;
  sq_t               r2_q, dx2_q, dy2_q;
  logic              busy_q, done_q, pend_q, rfr_q, qv_q;
  logic [V_ROWS-1:0] nc_q, terrain_q, bm_d;

  coord_t rd_a, rd_b, addr_a, addr_b, wd_b, pf_x_d, xs_d, xe_d, floor_d;
  logic   we_b, over_d;
  logic [10:0] dx_d, dx_abs_d, mul_a_d, xe_sum_d, fl_sum_d;
  sq_t    mul_p_d;

  terrain_ram u_ram (
    .clk   (Clk),
    .addr_a(addr_a),
    .q_a   (rd_a),
    .addr_b(addr_b),
    .we_b  (we_b),
    .wd_b  (wd_b),
    .q_b   (rd_b)
  );

  // Prefetch the column after DrawX; after a jump, spend one cycle fetching DrawX itself.
  assign pf_x_d = (DrawX == LAST_COL) ? '0 : DrawX + 10'd1;
  assign addr_a = pend_q ? last_x_q : pf_x_d;

  // Surface row to bitmap: row y is solid iff y >= h.
  for (genvar gi = 0; gi < V_ROWS; gi++) begin : g_bm
    assign bm_d[gi] = (coord_t'(gi) >= rd_a);
  end

  // Carve geometry: the single multiplier squares r in IDLE and |dx| in RD.
  assign dx_d     = {1'b0, col_q} - {1'b0, x_q};
  assign dx_abs_d = dx_d[10] ? (~dx_d + 11'd1) : dx_d;
  assign mul_a_d  = (state_q == IDLE) ? {5'b0, carve_r} : dx_abs_d;
  assign mul_p_d  = {11'b0, mul_a_d} * {11'b0, mul_a_d};
  assign xs_d     = (carve_x >= {4'b0, carve_r}) ? carve_x - {4'b0, carve_r} : '0;
  assign xe_sum_d = {1'b0, carve_x} + {5'b0, carve_r};
  assign xe_d     = (xe_sum_d > {1'b0, LAST_COL}) ? LAST_COL : xe_sum_d[9:0];
  assign over_d   = ({1'b0, dx2_q} + {1'b0, dy2_q}) > {1'b0, r2_q};
  assign fl_sum_d = {1'b0, y_q} + {5'b0, dy_q};
  assign floor_d  = (fl_sum_d > {1'b0, FLOOR_Y}) ? FLOOR_Y : fl_sum_d[9:0];

  // Port B arbitration: queries only while idle, otherwise the FSM column.
  always_comb begin
    addr_b = (state_q == IDLE) ? query_x : col_q;
    we_b   = 1'b0;
    wd_b   = INIT_H;
    if (state_q == INIT) begin
      we_b = 1'b1;
    end else if ((state_q == WR) && (rd_b < floor_d)) begin
      we_b = 1'b1;
      wd_b = floor_d;
    end
  end

  // Carve/init FSM with registered busy/done.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= INIT;
      col_q   <= '0;
      xe_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      r_q     <= '0;
      dy_q    <= '0;
      r2_q    <= '0;
      dx2_q   <= '0;
      dy2_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        INIT: begin
          if (col_q == LAST_COL) begin
            col_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            col_q <= col_q + 10'd1;
          end
        end
        IDLE: begin
          if (carve_req) begin
            x_q     <= carve_x;
            y_q     <= carve_y;
            r_q     <= carve_r;
            r2_q    <= mul_p_d;
            col_q   <= xs_d;
            xe_q    <= xe_d;
            busy_q  <= 1'b1;
            state_q <= RD;
          end
        end
        RD: begin
          dx2_q   <= mul_p_d;
          dy_q    <= r_q;
          dy2_q   <= r2_q;
          state_q <= SRCH;
        end
        SRCH: begin
          if (over_d) begin
            dy_q  <= dy_q - 6'd1;
            dy2_q <= dy2_q - {15'b0, dy_q, 1'b0} + 22'd1;
          end else begin
            state_q <= WR;
          end
        end
        WR: begin
          if (col_q >= xe_q) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            col_q   <= col_q + 10'd1;
            state_q <= RD;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  // Display pipeline: swap in the prefetched column when DrawX advances onto it.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      last_x_q  <= '0;
      ax1_q     <= '0;
      nc_x_q    <= '0;
      nc_q      <= '0;
      terrain_q <= '0;
      pend_q    <= 1'b0;
      rfr_q     <= 1'b0;
    end else begin
      ax1_q  <= addr_a;
      nc_q   <= bm_d;
      nc_x_q <= ax1_q;
      pend_q <= 1'b0;
      rfr_q  <= pend_q;
      if (DrawX != last_x_q) begin
        last_x_q <= DrawX;
        rfr_q    <= 1'b0;
        if (DrawX == nc_x_q) terrain_q <= nc_q;
        else pend_q <= 1'b1;
      end else if (rfr_q && (ax1_q == last_x_q)) begin
        terrain_q <= bm_d;
      end
    end
  end

  // Query result is live one cycle after an idle read, frozen otherwise.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      qv_q   <= 1'b0;
      hold_q <= '0;
    end else begin
      qv_q <= (state_q == IDLE);
      if (qv_q) hold_q <= rd_b;
    end
  end

  assign query_h      = qv_q ? rd_b : hold_q;
  assign terrain_data = terrain_q;
  assign carve_busy   = busy_q;
  assign carve_done   = done_q;

endmodule

// File: tb/tb_terrain_column_gen.sv
// Directed bench for terrain_column_gen: init, display sweep, carving, reset abort.
module tb_terrain_column_gen;

  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic [9:0]   DrawX = '0;
  logic [511:0] terrain_data;
  logic         carve_req = 1'b0;
  logic [9:0]   carve_x = '0;
  logic [9:0]   carve_y = '0;
  logic [5:0]   carve_r = '0;
  logic         carve_busy;
  logic         carve_done;
  logic [9:0]   query_x = '0;
  logic [9:0]   query_h;

  int n_chk = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int h_m [640];

  terrain_column_gen dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .terrain_data(terrain_data),
    .carve_req(carve_req), .carve_x(carve_x), .carve_y(carve_y), .carve_r(carve_r),
    .carve_busy(carve_busy), .carve_done(carve_done),
    .query_x(query_x), .query_h(query_h)
  );

  always #10 Clk = ~Clk;

  always @(negedge Clk) if (carve_done === 1'b1) done_cnt++;

  function automatic logic [511:0] bm(input int h);
    logic [511:0] b;
    for (int y = 0; y < 512; y++) b[y] = (y >= h);
    return b;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_h(input int c, input int exp);
    query_x = 10'(c);
    tick();
    chk($sformatf("h[%0d]", c), 512'(query_h), 512'(exp));
  endtask

  task automatic start_carve(input int x, input int y, input int r);
    carve_x = 10'(x);
    carve_y = 10'(y);
    carve_r = 6'(r);
    carve_req = 1'b1;
    tick();
    carve_req = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (carve_busy !== 1'b0 && k < 20000) begin
      tick();
      k++;
    end
    chk(tag, 512'(carve_busy), 512'(0));
  endtask

  task automatic model_carve(input int x, input int y, input int r);
    int lo, hi, dx, dy, fl;
    lo = (x - r < 0) ? 0 : x - r;
    hi = (x + r > 639) ? 639 : x + r;
    for (int c = lo; c <= hi; c++) begin
      dx = c - x;
      dy = r;
      while (dx * dx + dy * dy > r * r) dy--;
      fl = (y + dy > 480) ? 480 : y + dy;
      if (h_m[c] < fl) h_m[c] = fl;
    end
  endtask

  task automatic init_phase(input string tag);
    logic all_busy = 1'b1;
    for (int i = 0; i < 639; i++) begin
      tick();
      if (carve_busy !== 1'b1) all_busy = 1'b0;
    end
    chk({tag, "_busy_held"}, 512'(all_busy), 512'(1));
    tick();
    chk({tag, "_busy_fall_640"}, 512'(carve_busy), 512'(0));
  endtask

  initial begin
    int base;

    // 1: reset values, init length, first query
    tick();
    chk("rst_terrain", terrain_data, '0);
    chk("rst_query_h", 512'(query_h), 512'(0));
    chk("rst_busy", 512'(carve_busy), 512'(1));
    chk("rst_done", 512'(carve_done), 512'(0));
    tick();
    tick();
    Reset = 1'b1;
    init_phase("init");
    for (int c = 0; c < 640; c++) h_m[c] = 400;
    query_x = 10'd0;
    tick();
    chk("query0_after_init", 512'(query_h), 512'(400));

    // 2: jump to 639, then sweep 0..639 with 2-clock spacing (wrap 639->0)
    DrawX = 10'd639;
    tick(); tick(); tick();
    chk("jump_639", terrain_data, bm(400));
    for (int c = 0; c < 640; c++) begin
      tick();
      DrawX = 10'(c);
      tick();
      chk($sformatf("sweep_%0d", c), terrain_data, bm(h_m[c]));
    end

    // 3: crater x=100 y=400 r=10
    base = done_cnt;
    start_carve(100, 400, 10);
    wait_idle("carve3_finish");
    tick(); tick(); tick();
    chk("carve3_done_once", 512'(done_cnt - base), 512'(1));
    model_carve(100, 400, 10);
    chk_h(100, 410);
    chk_h(106, 408);
    chk_h(94, 408);
    chk_h(90, 400);
    chk_h(110, 400);
    chk_h(89, 400);

    // 4: left-edge clamp, floor clamp, request while busy ignored
    base = done_cnt;
    start_carve(2, 470, 20);
    tick(); tick(); tick(); tick(); tick();
    carve_x = 10'd300;
    carve_y = 10'd400;
    carve_r = 6'd10;
    carve_req = 1'b1;
    tick();
    carve_req = 1'b0;
    wait_idle("carve4_finish");
    repeat (20) tick();
    chk("carve4_done_once", 512'(done_cnt - base), 512'(1));
    chk("carve4_idle_after", 512'(carve_busy), 512'(0));
    model_carve(2, 470, 20);
    chk_h(2, 480);
    chk_h(0, 480);
    chk_h(22, 470);
    chk_h(23, 400);
    chk_h(300, 400);
    for (int c = 0; c < 31; c++) begin
      tick();
      DrawX = 10'(c);
      tick();
      chk($sformatf("carved_col_%0d", c), terrain_data, bm(h_m[c]));
    end

    // 6: crater entirely above the surface: no writes, done still pulses, query holds
    chk_h(100, 410);
    base = done_cnt;
    start_carve(50, 300, 5);
    query_x = 10'd2;
    tick(); tick(); tick();
    chk("query_hold_busy", 512'(query_h), 512'(410));
    wait_idle("carve6_finish");
    tick(); tick(); tick();
    chk("carve6_done_once", 512'(done_cnt - base), 512'(1));
    for (int c = 45; c <= 55; c++) chk_h(c, 400);

    // 5: reset mid-carve aborts and reflattens
    base = done_cnt;
    start_carve(300, 400, 30);
    repeat (100) tick();
    chk("carve5_midway_busy", 512'(carve_busy), 512'(1));
    Reset = 1'b0;
    tick();
    chk("abort_terrain_zero", terrain_data, '0);
    chk("abort_query_zero", 512'(query_h), 512'(0));
    tick();
    tick();
    Reset = 1'b1;
    init_phase("reinit");
    chk("abort_no_done", 512'(done_cnt - base), 512'(0));
    for (int c = 0; c < 640; c++) chk_h(c, 400);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/terrain_column_gen.md
Name: terrain_column_gen

Overview:
- Owns the terrain heightmap: 640 columns, each holding a surface row.
- Produces the 512-bit per-column terrain bitmap that the colour mapper indexes by DrawY. The bitmap is always ready and stable when DrawX arrives at a column.
- Writer side of the same data: carves circular craters on request from the bomb logic.
- Answers ground-height queries from the player/bomb physics.

Parameters:
- H_ACTIVE, 640, number of terrain columns.
- V_ROWS, 512, bitmap width (bits per column).
- FLOOR_Y, 480, surface value meaning "no terrain in column".
- INIT_H, 400, surface row written to every column at reset.
- R_MAX, 63, largest accepted crater radius.

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset  in  1  asynchronous, active-low reset.
- DrawX  in  10  current VGA pixel column; changes at most every 2 Clk.
- terrain_data  out  512  bitmap for column DrawX; bit y=1 iff terrain occupies row y.
- carve_req  in  1  one-cycle request to carve a crater.
- carve_x  in  10  crater centre column.
- carve_y  in  10  crater centre row.
- carve_r  in  6  crater radius.
- carve_busy  out  1  block is initialising or carving.
- carve_done  out  1  one-cycle pulse when a carve completes.
- query_x  in  10  column for ground-height query.
- query_h  out  10  surface row of column query_x.

Behaviour:
- Storage is a 640x10 heightmap RAM, dual-port, 1-cycle synchronous read.
  - Port A is dedicated to display prefetch.
  - Port B serves init, carve and query.
- Bitmap rule: bit y = 1 iff y >= h. So h=FLOOR_Y gives bits 480..511 set, which are never displayed. h=0 gives all bits set.
- Display prefetch:
  - pf_x is held at DrawX+1, wrapping 639 to 0.
  - Each cycle the block reads port A at pf_x and registers the result into next_col as a bitmap, so latency is 2 Clk.
  - On the Clk edge where DrawX differs from last_x: last_x <= DrawX. If DrawX equals the column held in next_col, terrain_data <= next_col. Otherwise (a jump, e.g. retrace) terrain_data is refreshed 2 Clk later.
  - A write landing on the column currently in next_col during the same cycle is not required to be visible until the next frame.
- Query: query_h <= RAM[query_x] via port B, 1-cycle latency, only in IDLE. While carve_busy is high, query_h holds its last value.
- FSM states: INIT, IDLE, RD, SRCH, WR.
  - Reset asserted (async): state=INIT, terrain_data=0, query_h=0, carve_busy=1, carve_done=0, column counter=0.
  - INIT: writes INIT_H to column cnt each cycle, 640 cycles, then IDLE.
  - IDLE: carve_busy=0. carve_req=1 latches x, y and r, then goes to RD. Column range is xs = max(0, x-r) to xe = min(639, x+r). A request with r=0 carves column x only.
  - RD: reads h[xc] on port B. dx = xc - x, signed 11-bit. dy = r. Go to SRCH.
  - SRCH: while dx*dx + dy*dy > r*r, dy--, one step per cycle. This needs one multiplier; it is the only product. Exit to WR.
  - WR: floor = min(y+dy, FLOOR_Y). If h < floor, write floor; else no write. If xc=xe, pulse carve_done for 1 cycle and go to IDLE. Otherwise xc++ and go to RD.
  - Worst case is about 127 columns x 66 cycles, which is under 9000 Clk.
- carve_req while busy (INIT or carving) is ignored and not queued.
- carve_y+dy overflow is computed in 11 bits and saturated by the FLOOR_Y clamp.
- Reset mid-carve aborts the carve; carve_done does not fire and INIT reflattens all columns.

Decomposition:
- Shared package game_pkg holds:
  - constants H_ACTIVE, V_ROWS, FLOOR_Y;
  - typedef coord_t (logic [9:0]);
  - enum carve_state_t {INIT, IDLE, RD, SRCH, WR}.
- One sub-module, terrain_ram: 640x10 dual-port synchronous RAM with write on port B, inferable as M9K.

Test Plan:
1. Reset low for 3 Clk, then high, wait 640 Clk. Expect carve_busy to fall after exactly 640 cycles, query_x=0 to give query_h=400, and every column's terrain_data = bits 400..511 set.
2. Sweep DrawX 0..639 every 2 Clk. At each change, terrain_data equals the bitmap for that column with no lag; the wrap from 639 to 0 is correct.
3. Carve x=100, y=400, r=10. Expect:
   - h[100]=410 and h[106]=408, since 6²+8²=100.
   - h[90] and h[110] = 400 (dy=0, no write).
   - h[89] unchanged.
   - carve_done pulses once.
4. Carve x=2, y=470, r=20. Expect:
   - xs clamps to 0 and h[2]=480, clamped by FLOOR_Y.
   - No write outside columns 0..22.
   - A second carve_req during busy is ignored.
5. Assert Reset mid-carve at x=300, r=30. Expect no carve_done, carve_busy=1 through INIT, then all columns 400.
6. Carve x=50, y=300, r=5 where h=400. Expect no writes, since h exceeds every floor value, and carve_done still pulses.
